// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_bus_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef enum logic [0:0] {StIdle, StBusy} arb_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter2_rr_pick2.sv
// Two-way round-robin chooser: on contention the requester other than `last` wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       pick_valid
);

    always_comb begin
        pick_valid = |req;
        pick       = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin arbiter sharing one memory port between two masters, with a
// watchdog that completes transactions the memory never acknowledges.
module mem_arbiter2
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int unsigned WdogW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WdogW-1:0] WdogMax = TIMEOUT[WdogW-1:0];

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;

    mem_req_t m0_req, m1_req, owner_req;
    logic     owner_valid, busy, wdog_hit, timeout_now, owner_rdy;
    logic     pick, pick_valid;

    assign m0_req = '{addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req = '{addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

    rr_pick2 u_pick (
        .req        ({m1_valid, m0_valid}),
        .last       (last_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_comb begin
        owner_req   = owner_q ? m1_req : m0_req;
        owner_valid = owner_q ? m1_valid : m0_valid;
        busy        = (state_q == StBusy);
        wdog_hit    = (TIMEOUT != 0) && (wdog_q == WdogMax);
        // A coincident mem_ready is a normal completion, never a timeout.
        timeout_now = busy && owner_valid && !mem_ready && wdog_hit;
        // Readies are suppressed while reset is held so an aborted transfer never completes.
        owner_rdy   = !reset && (mem_ready || timeout_now);
    end

    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        grant     = 2'b00;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = mem_rdata;
        m1_rdata  = mem_rdata;
        if (busy) begin
            grant     = onehot2(owner_q);
            mem_valid = owner_valid && !timeout_now;
            mem_addr  = owner_req.addr;
            mem_wdata = owner_req.wdata;
            mem_wstrb = owner_req.wstrb;
            if (owner_q) begin
                m1_ready = owner_rdy;
                if (timeout_now) m1_rdata = ERR_DATA;
            end else begin
                m0_ready = owner_rdy;
                if (timeout_now) m0_rdata = ERR_DATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StBusy;
                    owner_d = pick;
                    wdog_d  = '0;
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                end else if (!owner_valid) begin
                    state_d = StIdle;
                end else if (wdog_hit) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    assign timeout_err = err_q;

endmodule
